// File: rtl/bsg_id_pool_rr_alloc_arbiter.sv
// bsg_id_pool_rr_alloc_arbiter
//
// Lets several requesters share one one-hot ID pool. Each cycle at most one
// eligible requester is picked round-robin. The arbiter accepts the pool's
// offered ID for that requester and returns the ID one cycle later. It records
// which requester owns each outstanding ID, limits each requester to quota_p
// outstanding IDs, and checks releases before passing them on to the pool.
//
// Ports
//   clk_i                    clock
//   reset_n_i                asynchronous active-low reset
//   req_v_i       [reqs_p]   per-requester level request for one ID
//   grant_v_o     [reqs_p]   registered one-hot0 grant pulse
//   grant_id_one_hot_o [els_p] registered ID of the current grant (0 if none)
//   release_ids_i [els_p]    IDs being returned, from any requester(s)
//   pool_alloc_id_one_hot_i  pool's offered ID
//   pool_alloc_id_v_i        pool offer valid
//   pool_alloc_yumi_o        accept the offered ID (combinational)
//   pool_dealloc_ids_o       validated releases to the pool (combinational)
//   outstanding_o            registered per-requester outstanding counts, packed
//   err_o                    sticky illegal-release flag
//
// The parameter defaults exist only so the module can be elaborated on its
// own. Integrators always set els_p and reqs_p explicitly.
module bsg_id_pool_rr_alloc_arbiter #(
  parameter int els_p   = 8,
  parameter int reqs_p  = 3,
  parameter int quota_p = els_p
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [reqs_p-1:0]                     req_v_i,
  output logic [reqs_p-1:0]                     grant_v_o,
  output logic [els_p-1:0]                      grant_id_one_hot_o,
  input  logic [els_p-1:0]                      release_ids_i,
  input  logic [els_p-1:0]                      pool_alloc_id_one_hot_i,
  input  logic                                  pool_alloc_id_v_i,
  output logic                                  pool_alloc_yumi_o,
  output logic [els_p-1:0]                      pool_dealloc_ids_o,
  output logic [reqs_p*$clog2(quota_p+1)-1:0]   outstanding_o,
  output logic                                  err_o
);

  localparam int cnt_w = $clog2(quota_p + 1);
  localparam int own_w = (reqs_p > 1) ? $clog2(reqs_p) : 1;

  logic [els_p-1:0]  owned_r;
  logic [own_w-1:0]  owner_r [els_p];
  logic [cnt_w-1:0]  count_r [reqs_p];
  logic [cnt_w-1:0]  count_n [reqs_p];
  logic [own_w-1:0]  rr_start_r;   // first index searched in the next arbitration
  logic [reqs_p-1:0] grant_v_r;
  logic [els_p-1:0]  grant_id_r;
  logic              err_r;

  logic [reqs_p-1:0] elig;
  logic              accept;
  logic [own_w-1:0]  win;
  logic [own_w-1:0]  win_nxt;
  logic [els_p-1:0]  legal;
  logic              illegal;

  // Eligibility uses only the registered count. A release in this cycle does
  // not make a full requester eligible until the next cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    elig = '0;
    for (int r = 0; r < reqs_p; r++)
      elig[r] = req_v_i[r] && (count_r[r] < cnt_w'(quota_p));
  end

  // Round-robin arbiter. Rotate the eligibility vector so that rr_start_r
  // lands at bit 0, take the first set bit, then map that offset back to a
  // requester index.
  always_comb begin
    logic [2*reqs_p-1:0] elig_dbl;
    logic [reqs_p-1:0]   elig_rot;
    logic [own_w-1:0]    off;
    logic                found;
    logic [own_w:0]      sum;
    logic [own_w:0]      inc;
    elig_dbl = {elig, elig} >> rr_start_r;
    elig_rot = elig_dbl[reqs_p-1:0];
    off      = '0;
    found    = 1'b0;
    for (int k = 0; k < reqs_p; k++) begin
      if (!found && elig_rot[k]) begin
        found = 1'b1;
        off   = own_w'(k);
      end
    end
    sum = {1'b0, rr_start_r} + {1'b0, off};
    if (sum >= (own_w+1)'(reqs_p)) sum = sum - (own_w+1)'(reqs_p);
    win = sum[own_w-1:0];
    inc = {1'b0, win} + (own_w+1)'(1);
    if (inc >= (own_w+1)'(reqs_p)) inc = '0;
    win_nxt = inc[own_w-1:0];
  end

  // The yumi does not depend on release_ids_i. This keeps the pool's own
  // alloc/dealloc ordering intact.
  assign accept            = pool_alloc_id_v_i && (|elig);
  assign pool_alloc_yumi_o = accept;

  // Only IDs that are registered as owned may be released. A grant that is
  // still in flight is not owned yet, so releasing it here counts as illegal.
  assign legal              = release_ids_i & owned_r;
  assign illegal            = |(release_ids_i & ~owned_r);
  assign pool_dealloc_ids_o = legal;

  // Next count per requester: +1 for its grant, minus the number of legal
  // releases of IDs it owns in this cycle.
  always_comb begin
    logic [cnt_w-1:0] rel_cnt;
    for (int r = 0; r < reqs_p; r++) begin
      rel_cnt = '0;
      for (int i = 0; i < els_p; i++)
        if (legal[i] && (owner_r[i] == own_w'(r))) rel_cnt = rel_cnt + cnt_w'(1);
      count_n[r] = count_r[r] + cnt_w'(accept && (win == own_w'(r))) - rel_cnt;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      owned_r    <= '0;
      rr_start_r <= '0;
      grant_v_r  <= '0;
      grant_id_r <= '0;
      err_r      <= 1'b0;
      for (int r = 0; r < reqs_p; r++) count_r[r] <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
      owned_r    <= (owned_r & ~legal) | (accept ? pool_alloc_id_one_hot_i : '0);
      count_r    <= count_n;
      grant_v_r  <= accept ? (reqs_p'(1) << win) : '0;
      grant_id_r <= accept ? pool_alloc_id_one_hot_i : '0;
      if (accept)  rr_start_r <= win_nxt;
      if (illegal) err_r      <= 1'b1;
    end
  end

  // NOTE: the owner table has no reset; an entry is only read while its owned_r bit is set.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < els_p; i++)
      if (accept && pool_alloc_id_one_hot_i[i]) owner_r[i] <= win;
  end

  assign grant_v_o          = grant_v_r;
  assign grant_id_one_hot_o = grant_id_r;
  assign err_o              = err_r;

  for (genvar g = 0; g < reqs_p; g++) begin : g_out
    assign outstanding_o[g*cnt_w +: cnt_w] = count_r[g];

    a_quota : assert property (@(posedge clk_i) disable iff (!reset_n_i)
                               count_r[g] <= cnt_w'(quota_p));
  end

  a_grant_onehot0 : assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                     $onehot0(grant_v_o));
  a_yumi_needs_v  : assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                     pool_alloc_yumi_o |-> pool_alloc_id_v_i);

endmodule

// File: tb/tb_bsg_id_pool_rr_alloc_arbiter.sv
// Testbench for bsg_id_pool_rr_alloc_arbiter (els_p=8, reqs_p=3, quota_p=2).
// The bench plays the role of the pool. Its reference model keeps an
// owner-per-ID table and derives counts, eligibility and round-robin order
// from that table.
module tb_bsg_id_pool_rr_alloc_arbiter;

  localparam int ELS   = 8;
  localparam int REQS  = 3;
  localparam int QUOTA = 2;
  localparam int CW    = $clog2(QUOTA + 1);

  logic              clk = 1'b0;
  logic              reset_n;
  logic [REQS-1:0]   req_v;
  logic [REQS-1:0]   grant_v;
  logic [ELS-1:0]    grant_id;
  logic [ELS-1:0]    release_ids;
  logic [ELS-1:0]    pool_id;
  logic              pool_v;
  logic              yumi;
  logic [ELS-1:0]    dealloc;
  logic [REQS*CW-1:0] outstanding;
  logic              err;

  always #5 clk = ~clk;

  bsg_id_pool_rr_alloc_arbiter #(
    .els_p(ELS), .reqs_p(REQS), .quota_p(QUOTA)
  ) dut (
    .clk_i                   (clk),
    .reset_n_i               (reset_n),
    .req_v_i                 (req_v),
    .grant_v_o               (grant_v),
    .grant_id_one_hot_o      (grant_id),
    .release_ids_i           (release_ids),
    .pool_alloc_id_one_hot_i (pool_id),
    .pool_alloc_id_v_i       (pool_v),
    .pool_alloc_yumi_o       (yumi),
    .pool_dealloc_ids_o      (dealloc),
    .outstanding_o           (outstanding),
    .err_o                   (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  int              owner_of [ELS];   // -1 = free
  int              last_w;
  bit              err_m;
  logic [REQS-1:0] exp_grant_v;
  logic [ELS-1:0]  exp_grant_id;
  logic            exp_yumi;
  logic [ELS-1:0]  exp_dealloc;
  bit              exp_illegal;
  int              exp_winner;
  logic            obs_yumi;
  logic [ELS-1:0]  obs_dealloc;
  bit              auto_pool = 1'b1;
  bit              rand_pool = 1'b0;

  function automatic int held_by(int r);
    int n = 0;
    for (int i = 0; i < ELS; i++) if (owner_of[i] == r) n++;
    return n;
  endfunction

  function automatic logic [REQS*CW-1:0] exp_outstanding();
    logic [REQS*CW-1:0] v = '0;
    for (int r = 0; r < REQS; r++) v[r*CW +: CW] = CW'(held_by(r));
    return v;
  endfunction

  function automatic int dut_out(int r);
    return int'(outstanding[r*CW +: CW]);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ELS; i++) owner_of[i] = -1;
    last_w       = REQS - 1;
    err_m        = 1'b0;
    exp_grant_v  = '0;
    exp_grant_id = '0;
  endfunction

  function automatic void offer_free();
    int free_q[$];
    int j;
    for (int i = 0; i < ELS; i++) if (owner_of[i] < 0) free_q.push_back(i);
    pool_id = '0;
    pool_v  = 1'b0;
    if (free_q.size() != 0 && (!rand_pool || $urandom_range(0, 4) != 0)) begin
      pool_v = 1'b1;
      j = rand_pool ? free_q[$urandom_range(0, free_q.size() - 1)] : free_q[0];
      pool_id[j] = 1'b1;
    end
  endfunction

  function automatic void model_comb();
    bit elig_any = 1'b0;
    exp_winner = -1;
    for (int k = 1; k <= REQS; k++) begin
      int r = (last_w + k) % REQS;
      if (req_v[r] && held_by(r) < QUOTA) begin
        elig_any = 1'b1;
        if (exp_winner < 0) exp_winner = r;
      end
    end
    exp_yumi    = pool_v && elig_any;
    exp_dealloc = '0;
    exp_illegal = 1'b0;
    for (int i = 0; i < ELS; i++)
      if (release_ids[i]) begin
        if (owner_of[i] >= 0) exp_dealloc[i] = 1'b1;
        else exp_illegal = 1'b1;
      end
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < ELS; i++) if (exp_dealloc[i]) owner_of[i] = -1;
    if (exp_illegal) err_m = 1'b1;
    exp_grant_v  = '0;
    exp_grant_id = '0;
    if (exp_yumi) begin
      for (int i = 0; i < ELS; i++) if (pool_id[i]) owner_of[i] = exp_winner;
      last_w = exp_winner;
      exp_grant_v[exp_winner] = 1'b1;
      exp_grant_id = pool_id;
    end
  endfunction

  // One clock cycle: sample combinational outputs before the edge, advance
  // the model at the edge, and return 1 time unit after the edge.
  task automatic cycle();
    if (auto_pool) offer_free();
    @(negedge clk);
    model_comb();
    obs_yumi    = yumi;
    obs_dealloc = dealloc;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_v = '0; release_ids = '0; pool_id = '0; pool_v = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (grant_v !== '0) begin n_fail++; $display("FAIL reset_grant_v got %h want 0", grant_v); end
    n_checks++; if (grant_id !== '0) begin n_fail++; $display("FAIL reset_grant_id got %h want 0", grant_id); end
    n_checks++; if (outstanding !== '0) begin n_fail++; $display("FAIL reset_outstanding got %h want 0", outstanding); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_checks++; if (dealloc !== '0) begin n_fail++; $display("FAIL reset_dealloc got %h want 0", dealloc); end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_round_robin();
    logic [REQS-1:0] want_v;
    logic [ELS-1:0]  want_id;
    auto_pool = 1'b1; rand_pool = 1'b0;
    req_v = '1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      want_v = '0; want_v[k % REQS] = 1'b1;
      want_id = '0; want_id[k] = 1'b1;
      n_checks++; if (obs_yumi !== 1'b1) begin n_fail++; $display("FAIL rr_yumi[%0d] got %b want 1", k, obs_yumi); end
      n_checks++; if (grant_v !== want_v) begin n_fail++; $display("FAIL rr_grant_v[%0d] got %b want %b", k, grant_v, want_v); end
      n_checks++; if (grant_id !== want_id) begin n_fail++; $display("FAIL rr_grant_id[%0d] got %h want %h", k, grant_id, want_id); end
      n_checks++; if (outstanding !== exp_outstanding()) begin n_fail++; $display("FAIL rr_outstanding[%0d] got %h want %h", k, outstanding, exp_outstanding()); end
    end
    // Every requester is now at quota.
    cycle();
    n_checks++; if (obs_yumi !== 1'b0) begin n_fail++; $display("FAIL rr_full_yumi got %b want 0", obs_yumi); end
    n_checks++; if (grant_v !== '0) begin n_fail++; $display("FAIL rr_full_grant got %b want 0", grant_v); end
    n_checks++; if (outstanding !== {CW'(2), CW'(2), CW'(2)}) begin n_fail++; $display("FAIL rr_full_outstanding got %h want all 2", outstanding); end
    req_v = '0; release_ids = 8'h3F;
    cycle();
    n_checks++; if (obs_dealloc !== 8'h3F) begin n_fail++; $display("FAIL rr_release_dealloc got %h want 3f", obs_dealloc); end
    n_checks++; if (outstanding !== '0) begin n_fail++; $display("FAIL rr_release_outstanding got %h want 0", outstanding); end
    release_ids = '0;
  endtask

  task automatic test_quota();
    req_v = 3'b010;
    cycle();
    n_checks++; if (grant_v !== 3'b010 || dut_out(1) != 1) begin n_fail++; $display("FAIL quota_g1 got %b/%0d want 010/1", grant_v, dut_out(1)); end
    cycle();
    n_checks++; if (grant_v !== 3'b010 || dut_out(1) != 2) begin n_fail++; $display("FAIL quota_g2 got %b/%0d want 010/2", grant_v, dut_out(1)); end
    cycle();
    n_checks++; if (obs_yumi !== 1'b0 || grant_v !== '0) begin n_fail++; $display("FAIL quota_block got yumi %b grant %b want 0/0", obs_yumi, grant_v); end
    release_ids = 8'h01;
    cycle();
    n_checks++; if (obs_dealloc !== 8'h01 || obs_yumi !== 1'b0) begin n_fail++; $display("FAIL quota_rel got dealloc %h yumi %b want 01/0", obs_dealloc, obs_yumi); end
    n_checks++; if (dut_out(1) != 1) begin n_fail++; $display("FAIL quota_rel_count got %0d want 1", dut_out(1)); end
    release_ids = '0;
    cycle();
    n_checks++; if (obs_yumi !== 1'b1 || grant_v !== 3'b010 || grant_id !== 8'h01) begin n_fail++; $display("FAIL quota_resume got %b/%b/%h want 1/010/01", obs_yumi, grant_v, grant_id); end
    n_checks++; if (dut_out(1) != 2) begin n_fail++; $display("FAIL quota_resume_count got %0d want 2", dut_out(1)); end
    req_v = '0; release_ids = 8'h03;
    cycle();
    release_ids = '0;
  endtask

  task automatic test_same_cycle();
    req_v = 3'b001;
    cycle();
    n_checks++; if (grant_v !== 3'b001 || grant_id !== 8'h01 || dut_out(0) != 1) begin n_fail++; $display("FAIL same_setup got %b/%h/%0d want 001/01/1", grant_v, grant_id, dut_out(0)); end
    release_ids = 8'h01;
    cycle();
    n_checks++; if (obs_dealloc !== 8'h01 || obs_yumi !== 1'b1) begin n_fail++; $display("FAIL same_comb got dealloc %h yumi %b want 01/1", obs_dealloc, obs_yumi); end
    n_checks++; if (grant_v !== 3'b001 || grant_id !== 8'h02) begin n_fail++; $display("FAIL same_grant got %b/%h want 001/02", grant_v, grant_id); end
    n_checks++; if (dut_out(0) != 1) begin n_fail++; $display("FAIL same_count got %0d want 1", dut_out(0)); end
    req_v = '0; release_ids = 8'h02;
    cycle();
    release_ids = '0;
  endtask

  task automatic test_multi_release();
    auto_pool = 1'b0;
    req_v = 3'b001; pool_v = 1'b1; pool_id = 8'h01;
    cycle();
    pool_id = 8'h02;
    cycle();
    req_v = 3'b100; pool_id = 8'h10;
    cycle();
    n_checks++; if (grant_v !== 3'b100 || grant_id !== 8'h10) begin n_fail++; $display("FAIL multi_setup got %b/%h want 100/10", grant_v, grant_id); end
    n_checks++; if (dut_out(0) != 2 || dut_out(2) != 1) begin n_fail++; $display("FAIL multi_before got %0d/%0d want 2/1", dut_out(0), dut_out(2)); end
    req_v = '0; pool_v = 1'b0; pool_id = '0; release_ids = 8'h13;
    cycle();
    n_checks++; if (obs_dealloc !== 8'h13) begin n_fail++; $display("FAIL multi_dealloc got %h want 13", obs_dealloc); end
    n_checks++; if (dut_out(0) != 0 || dut_out(2) != 0) begin n_fail++; $display("FAIL multi_after got %0d/%0d want 0/0", dut_out(0), dut_out(2)); end
    release_ids = '0;
    auto_pool = 1'b1;
  endtask

  task automatic test_illegal_release();
    release_ids = 8'h80;
    cycle();
    n_checks++; if (obs_dealloc !== '0) begin n_fail++; $display("FAIL illegal_dealloc got %h want 0", obs_dealloc); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_err got %b want 1", err); end
    release_ids = '0;
    repeat (2) cycle();
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky got %b want 1", err); end
  endtask

  task automatic test_reset_mid();
    req_v = '1;
    cycle();
    n_checks++; if (grant_v !== exp_grant_v || grant_v === '0) begin n_fail++; $display("FAIL mid_pre_grant got %b want %b", grant_v, exp_grant_v); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (grant_v !== '0 || grant_id !== '0) begin n_fail++; $display("FAIL mid_grant got %b/%h want 0/0", grant_v, grant_id); end
    n_checks++; if (outstanding !== '0 || err !== 1'b0) begin n_fail++; $display("FAIL mid_state got %h/%b want 0/0", outstanding, err); end
    release_ids = 8'hFF;
    #1;
    n_checks++; if (dealloc !== '0) begin n_fail++; $display("FAIL mid_dealloc got %h want 0", dealloc); end
    model_reset();
    release_ids = '0; req_v = '0; pool_v = 1'b0; pool_id = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    req_v = '1;
    cycle();
    n_checks++; if (grant_v !== 3'b001) begin n_fail++; $display("FAIL mid_first_grant got %b want 001", grant_v); end
    req_v = '0; release_ids = grant_id;
    cycle();
    release_ids = '0;
  endtask

  task automatic test_random();
    logic [ELS-1:0] rel;
    int j;
    rand_pool = 1'b1; auto_pool = 1'b1;
    for (int n = 0; n < 400; n++) begin
      req_v = REQS'($urandom_range(0, (1 << REQS) - 1));
      rel = '0;
      for (int i = 0; i < ELS; i++)
        if (owner_of[i] >= 0 && $urandom_range(0, 2) == 0) rel[i] = 1'b1;
      if ($urandom_range(0, 60) == 0) begin
        j = $urandom_range(0, ELS - 1);
        rel[j] = 1'b1;
      end
      release_ids = rel;
      cycle();
      n_checks++; if (obs_yumi !== exp_yumi) begin n_fail++; $display("FAIL rnd_yumi[%0d] got %b want %b", n, obs_yumi, exp_yumi); end
      n_checks++; if (obs_dealloc !== exp_dealloc) begin n_fail++; $display("FAIL rnd_dealloc[%0d] got %h want %h", n, obs_dealloc, exp_dealloc); end
      n_checks++; if (grant_v !== exp_grant_v) begin n_fail++; $display("FAIL rnd_grant_v[%0d] got %b want %b", n, grant_v, exp_grant_v); end
      n_checks++; if (grant_id !== exp_grant_id) begin n_fail++; $display("FAIL rnd_grant_id[%0d] got %h want %h", n, grant_id, exp_grant_id); end
      n_checks++; if (outstanding !== exp_outstanding()) begin n_fail++; $display("FAIL rnd_outstanding[%0d] got %h want %h", n, outstanding, exp_outstanding()); end
      n_checks++; if (err !== err_m) begin n_fail++; $display("FAIL rnd_err[%0d] got %b want %b", n, err, err_m); end
    end
    release_ids = '0; req_v = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_quota();
    test_same_cycle();
    test_multi_release();
    test_illegal_release();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_id_pool_rr_alloc_arbiter.md
# bsg_id_pool_rr_alloc_arbiter

Shares one one-hot ID pool among `reqs_p` requesters. Each cycle it picks at most one eligible requester round-robin, accepts the pool's offered ID on that requester's behalf, and returns the ID one cycle later. It records the owner of every outstanding ID and caps each requester at `quota_p` outstanding IDs. It sits between requester clients and the pool's alloc/dealloc ports, and it forwards and validates releases.

## Interface
- `els_p`, no default: number of IDs in the pool.
- `reqs_p`, no default: number of requesters, at least 1.
- `quota_p`, default `els_p`: maximum outstanding IDs per requester, in the range 1..`els_p`.

- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  one clock; reset is asynchronous and active-low.
- `req_v_i`  in  `reqs_p`  per-requester level request for one ID.
- `grant_v_o`  out  `reqs_p`  registered; one-hot or zero; one-cycle pulse per granted ID.
- `grant_id_one_hot_o`  out  `els_p`  registered ID for the current grant; zero when no bit of `grant_v_o` is set.
- `release_ids_i`  in  `els_p`  bitmask of IDs being returned, from any requester(s).
- `pool_alloc_id_one_hot_i`  in  `els_p`  pool's offered ID.
- `pool_alloc_id_v_i`  in  1  pool offer valid.
- `pool_alloc_yumi_o`  out  1  accept the offered ID; combinational.
- `pool_dealloc_ids_o`  out  `els_p`  validated releases to the pool; combinational.
- `outstanding_o`  out  `reqs_p` × `$clog2(quota_p+1)`  registered per-requester outstanding count.
- `err_o`  out  1  sticky; set when an illegal release is seen.

## Operation
- **Eligibility.** `elig[r] = req_v_i[r] & (count[r] < quota_p)`.
- **Pool accept.** `pool_alloc_yumi_o = pool_alloc_id_v_i & |elig`.
  - No dependence on `release_ids_i`, so the pool's alloc/dealloc ordering is preserved.
- **Arbitration.**
  - Round-robin over `elig`, starting at the index after the last granted requester.
  - After reset, search starts at index 0.
  - The pointer advances only on an accepted grant.
- **On accept, for winner `w` and ID `i`:**
  - `owned[i] <= 1`.
  - `owner[i] <= w`.
  - `count[w]` increments.
  - `grant_v_o <= onehot(w)`.
  - `grant_id_one_hot_o <= pool_alloc_id_one_hot_i`.
- **Release legality.**
  - `legal = release_ids_i & owned` (registered `owned` only).
  - `pool_dealloc_ids_o = legal`.
  - Any bit of `release_ids_i & ~owned` sets `err_o`; those bits are dropped.
- **On release:**
  - Each legal bit clears `owned[i]`.
  - `count[owner[i]]` decrements by the number of legal bits owned by that requester in the cycle (popcount per requester).
- **Simultaneous events.**
  - Grant and releases to the same requester in one cycle: `count` changes by +1 − releases.
  - A requester's own in-flight grant cannot be released in the accept cycle, because it is not yet owned. It becomes releasable from the cycle `grant_v_o` is high.
- **State.**
  - `owned` [`els_p`].
  - `owner` [`els_p`] × `$clog2(reqs_p)` (width 1 when `reqs_p` = 1).
  - `count` [`reqs_p`].
  - RR pointer.
  - Grant registers.
  - `err_o`.

## Timing
- **Reset values** (asserted asynchronously, removed synchronously by the integrator):
  - `grant_v_o` = 0, `grant_id_one_hot_o` = 0.
  - `outstanding_o` = 0, `err_o` = 0.
  - `owned` = 0, RR pointer = 0.
  - Combinational outputs evaluate to 0 because `owned` = 0.
- **Latency.** Accept in cycle N; `grant_v_o` and ID are valid in cycle N+1 for exactly one cycle.
- **Quota.**
  - A requester at `quota_p` is skipped; other eligible requesters are served in the same cycle.
  - A release lowers the count in cycle N+1, so the requester is eligible again in cycle N+1.
- **Empty pool.** `pool_alloc_id_v_i` = 0 gives no yumi, no grant, and no pointer move.
- **Throughput.** Up to one grant per cycle; any number of releases per cycle.
- **Reset mid-operation.** All ownership and counts are discarded; the pool must be reset in the same cycles.
- **Assertions.**
  - `grant_v_o` is one-hot0.
  - `count[r]` never exceeds `quota_p`.
  - `pool_alloc_yumi_o` implies `pool_alloc_id_v_i`.

## Test plan
- **Reset.** Assert `reset_n_i`=0 mid-grant → all outputs 0 immediately. After release of reset, the first grant goes to requester 0.
- **Round-robin.** `reqs_p`=3, `els_p`=8, all requesting continuously → grants 0,1,2,0,1,2 with IDs 0x01,0x02,0x04,… each one cycle after yumi.
- **Quota.** `quota_p`=2, only requester 1 requesting → two grants, then `pool_alloc_yumi_o`=0. Release one of its IDs → grant resumes in the next cycle; `outstanding_o[1]` goes 2→1→2.
- **Same-cycle grant and release.** Requester 0 holds ID 0x01; it releases 0x01 in the same cycle it is granted 0x02 → `pool_dealloc_ids_o`=0x01 and `outstanding_o[0]` unchanged.
- **Multi-release.** Requester 0 owns 0x03 and requester 2 owns 0x10; `release_ids_i`=0x13 in one cycle → counts drop by 2 and 1 respectively.
- **Illegal release.** `release_ids_i`=0x80 with ID 7 not owned → `pool_dealloc_ids_o`=0 and `err_o`=1, held until reset.
